// File: rtl/axi_stream_mux_arbiter.sv
// Packet-aware round-robin arbiter that drives the select address of a registered 8:1
// AXI-stream mux. It holds each grant for a whole packet, then idles for a drain gap.
module axi_stream_mux_arbiter #(
    parameter int unsigned N_INPUTS     = 8,
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned PACKET_MODE  = 1,
    parameter int unsigned SWITCH_GAP   = 2,
    parameter int unsigned HOLD_TIMEOUT = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [N_INPUTS-1:0]   request,
    input  logic                  beat_done,
    input  logic                  beat_last,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  grant_valid,
    output logic [N_INPUTS-1:0]   grant_onehot,
    output logic                  timeout_error
);

    localparam int unsigned GapWidth     = $clog2(SWITCH_GAP) + 1;
    localparam int unsigned TimeoutWidth = $clog2(HOLD_TIMEOUT) + 1;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StGranted = 2'd1;
    localparam logic [1:0] StGap     = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic                    grant_valid_q, grant_valid_d;
    logic [N_INPUTS-1:0]     grant_onehot_q, grant_onehot_d;
    logic                    timeout_error_q, timeout_error_d;
    logic [ADDR_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [GapWidth-1:0]     gap_cnt_q, gap_cnt_d;
    logic [TimeoutWidth-1:0] hold_cnt_q, hold_cnt_d;

    logic                    found;
    logic [ADDR_WIDTH-1:0]   winner;
    int unsigned             idx;
    logic                    release_ok;
    logic                    timeout_hit;

    // Round-robin search starting just after the last granted stream, so it is searched last.
    always_comb begin
        found  = 1'b0;
        winner = last_grant_q;
        idx    = 0;
        for (int unsigned i = 1; i <= N_INPUTS; i++) begin
            idx = int'(last_grant_q) + i;
            if (idx >= N_INPUTS) begin
                idx = idx - N_INPUTS;
            end
            if (!found && request[idx]) begin
                found  = 1'b1;
                winner = ADDR_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        address_d       = address_q;
        grant_valid_d   = grant_valid_q;
        grant_onehot_d  = grant_onehot_q;
        timeout_error_d = 1'b0;
        last_grant_d    = last_grant_q;
        gap_cnt_d       = gap_cnt_q;
        hold_cnt_d      = hold_cnt_q;
        release_ok      = beat_done && (beat_last || (PACKET_MODE == 0));
        timeout_hit     = !beat_done && (hold_cnt_q == TimeoutWidth'(HOLD_TIMEOUT - 1));

        case (state_q)
            StIdle: begin
                if (enable && found) begin
                    address_d      = winner;
                    grant_onehot_d = N_INPUTS'(1) << winner;
                    grant_valid_d  = 1'b1;
                    last_grant_d   = winner;
                    hold_cnt_d     = '0;
                    state_d        = StGranted;
                end
            end
            StGranted: begin
                hold_cnt_d = beat_done ? '0 : hold_cnt_q + TimeoutWidth'(1);
                // A completing beat takes priority over a coincident timeout.
                if (release_ok || timeout_hit) begin
                    grant_valid_d   = 1'b0;
                    grant_onehot_d  = '0;
                    timeout_error_d = timeout_hit && !release_ok;
                    hold_cnt_d      = '0;
                    if (SWITCH_GAP == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StGap;
                        gap_cnt_d = GapWidth'(SWITCH_GAP);
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GapWidth'(1);
                end
                if (gap_cnt_q <= GapWidth'(1)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            address_q       <= '0;
            grant_valid_q   <= 1'b0;
            grant_onehot_q  <= '0;
            timeout_error_q <= 1'b0;
            last_grant_q    <= ADDR_WIDTH'(N_INPUTS - 1);
            gap_cnt_q       <= '0;
            hold_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            address_q       <= address_d;
            grant_valid_q   <= grant_valid_d;
            grant_onehot_q  <= grant_onehot_d;
            timeout_error_q <= timeout_error_d;
            last_grant_q    <= last_grant_d;
            gap_cnt_q       <= gap_cnt_d;
            hold_cnt_q      <= hold_cnt_d;
        end
    end

    assign address       = address_q;
    assign grant_valid   = grant_valid_q;
    assign grant_onehot  = grant_onehot_q;
    assign timeout_error = timeout_error_q;

endmodule
